// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern generator for the ADV7513 path, pix_clk domain.
// Define VIDEO_TIMING_GEN_PATTERN_EN to build the runtime pattern selector; otherwise rgb is the shadowed solid colour.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          pix_clk,
  input  logic          RST_N,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          line_start,
  output logic [23:0]   rgb
);

  // Region boundaries as counter-width constants; "last" values are inclusive so a
  // zero back porch never needs a value one past the counter range.
  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_FIRST  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON     = (HS_POL != 0);
  localparam logic          VS_ON     = (VS_POL != 0);

  logic          run_q;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [23:0]   colour_q, colour_d;

  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic          ls_q, ls_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          pix_valid;
  logic          frame_origin;
  logic          shadow_load;
  logic          h_active, v_active;
  logic          h_in_sync, v_in_sync;
  logic [23:0]   pattern_rgb;

  // run_q delays the first counted pixel by one edge after enable, so pixel (0,0)
  // appears on the second edge exactly as it does after reset release.
  assign pix_valid    = en & run_q;
  assign frame_origin = (h_q == '0) && (v_q == '0);
  assign shadow_load  = ~pix_valid | frame_origin;

  assign h_active  = (h_q < H_ACT_END);
  assign v_active  = (v_q < V_ACT_END);
  assign h_in_sync = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign v_in_sync = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

  // The value taken at the frame origin is used for that pixel too, so a frame
  // is rendered entirely from one sample of the inputs.
  assign colour_d = shadow_load ? solid_rgb : colour_q;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  typedef enum logic [1:0] {
    PAT_SOLID    = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

  pattern_e    mode_q, mode_d;
  logic [7:0]  h_lo, v_lo;
  logic [2:0]  bar_idx;

  assign mode_d = shadow_load ? pattern_e'(mode) : mode_q;
  assign h_lo   = 8'(h_q);
  assign v_lo   = 8'(v_q);

  function automatic logic [XW-1:0] bar_edge(input int k);
    return XW'(k * H_ACTIVE / 8);
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Bar index = number of elaboration-time edges already passed; no divider.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_q >= bar_edge(k)) bar_idx = bar_idx + 3'd1;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pattern_rgb = colour_d;
    case (mode_d)
      PAT_SOLID:    pattern_rgb = colour_d;
      PAT_BARS:     pattern_rgb = bar_colour(bar_idx);
      PAT_CHECKER:  pattern_rgb = (h_lo[5] ^ v_lo[5]) ? 24'hFFFFFF : 24'h000000;
      PAT_GRADIENT: pattern_rgb = {h_lo, v_lo, h_lo ^ v_lo};
    endcase
  end

  always_ff @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) mode_q <= PAT_SOLID;
    else        mode_q <= mode_d;
  end
`else
  logic unused_mode;

  assign unused_mode = ^mode;
  assign pattern_rgb = colour_d;
`endif

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
      end else begin
        h_d = h_q + XW'(1);
      end
    end
  end

  always_comb begin
    de_d  = 1'b0;
    hs_d  = ~HS_ON;
    vs_d  = ~VS_ON;
    fs_d  = 1'b0;
    ls_d  = 1'b0;
    x_d   = '0;
    y_d   = '0;
    rgb_d = '0;
    if (pix_valid) begin
      de_d = h_active & v_active;
      hs_d = h_in_sync ? HS_ON : ~HS_ON;
      vs_d = v_in_sync ? VS_ON : ~VS_ON;
      fs_d = frame_origin;
      ls_d = (h_q == '0);
      x_d  = h_q;
      y_d  = v_q;
      if (h_active && v_active) rgb_d = pattern_rgb;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) begin
      run_q    <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      colour_q <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_ON;
      vs_q     <= ~VS_ON;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
    end else begin
      run_q    <= en;
      h_q      <= h_d;
      v_q      <= v_d;
      colour_q <= colour_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
      ls_q     <= ls_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_video_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 1;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam bit PATTERN_EN = 1'b1;
`else
  localparam bit PATTERN_EN = 1'b0;
`endif

  logic          pix_clk = 1'b0;
  logic          RST_N = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [23:0]   solid_rgb = 24'h0;
  logic          de, hsync, vsync, frame_start, line_start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [23:0]   rgb;

  int checks = 0;
  int errors = 0;

  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1), .VS_POL(0)
  ) dut (
    .pix_clk(pix_clk), .RST_N(RST_N), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start), .rgb(rgb)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] model_rgb(input int h, input int v, input logic [1:0] m,
                                            input logic [23:0] c);
    int bar;
    if (!PATTERN_EN) return c;
    case (m)
      2'd0: return c;
      2'd1: begin
        bar = 0;
        for (int k = 1; k < 8; k++) if (h >= k * HA / 8) bar++;
        return bar_rgb[bar];
      end
      2'd2: return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return {8'(h % 256), 8'(v % 256), 8'((h ^ v) % 256)};
    endcase
  endfunction

  int          run_n = 0;
  int          m_p, m_h, m_v;
  logic [23:0] fr_col = 24'h0;
  logic [1:0]  fr_mode = 2'd0;
  logic        exp_de = 1'b0, exp_hs = !HS_POL, exp_vs = !VS_POL, exp_fs = 1'b0, exp_ls = 1'b0;
  int          exp_x = 0, exp_y = 0;
  logic [23:0] exp_rgb = 24'h0;

  // Outputs after the n-th consecutive enabled edge show frame pixel (n-2) mod FRAME.
  always @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) begin
      run_n = 0;
      fr_col = 24'h0;
      fr_mode = 2'd0;
    end else begin
      run_n = en ? run_n + 1 : 0;
      if (run_n >= FRAME + 2) run_n -= FRAME;
    end
    if (!RST_N || run_n < 2) begin
      exp_de = 1'b0; exp_hs = !HS_POL; exp_vs = !VS_POL; exp_fs = 1'b0; exp_ls = 1'b0;
      exp_x = 0; exp_y = 0; exp_rgb = 24'h0;
    end else begin
      m_p = (run_n - 2) % FRAME;
      m_h = m_p % HT;
      m_v = m_p / HT;
      if (m_p == 0) begin
        fr_col = solid_rgb;
        fr_mode = mode;
      end
      exp_de  = (m_h < HA) && (m_v < VA);
      exp_hs  = (m_h >= HA + HFP && m_h < HA + HFP + HSW) ? HS_POL : !HS_POL;
      exp_vs  = (m_v >= VA + VFP && m_v < VA + VFP + VSW) ? VS_POL : !VS_POL;
      exp_fs  = (m_p == 0);
      exp_ls  = (m_h == 0);
      exp_x   = m_h;
      exp_y   = m_v;
      exp_rgb = exp_de ? model_rgb(m_h, m_v, fr_mode, fr_col) : 24'h0;
    end
  end

  always @(negedge pix_clk) begin
    check("ctl{de,hs,vs,fs,ls}", 64'({de, hsync, vsync, frame_start, line_start}),
          64'({exp_de, exp_hs, exp_vs, exp_fs, exp_ls}));
    check("x", 64'(x), 64'(exp_x));
    check("y", 64'(y), 64'(exp_y));
    check("rgb", 64'(rgb), 64'(exp_rgb));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fs(input string tag);
    bit hit = 1'b0;
    for (int k = 0; k < 2 * FRAME + 4 && !hit; k++) begin
      @(negedge pix_clk);
      hit = frame_start;
    end
    check({"wait_fs_", tag}, 64'(hit), 64'd1);
  endtask

  task automatic wait_pix(input int wx, input int wy, input string tag);
    bit hit = 1'b0;
    for (int k = 0; k < 2 * FRAME + 4 && !hit; k++) begin
      @(negedge pix_clk);
      hit = (int'(x) == wx) && (int'(y) == wy);
    end
    check({"wait_pix_", tag}, 64'(hit), 64'd1);
  endtask

  // Called on the cycle that shows frame_start; walks exactly one frame.
  task automatic measure_frame(input bit chk_rgb, input logic [23:0] want, input string tag);
    int n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, n_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (de) n_de++;
      if (hsync) n_hs++;
      if (!vsync) n_vs++;
      if (line_start) n_ls++;
      if (frame_start) n_fs++;
      if (hsync && (int'(x) < 10 || int'(x) > 12)) n_bad++;
      if (!vsync && (int'(y) < 5 || int'(y) > 6)) n_bad++;
      if (de && int'(y) >= 4) n_bad++;
      if (chk_rgb && de) check({tag, "_rgb"}, 64'(rgb), 64'(want));
      @(negedge pix_clk);
    end
    check({tag, "_de_cycles"}, 64'(n_de), 64'd32);
    check({tag, "_hsync_cycles"}, 64'(n_hs), 64'd24);
    check({tag, "_vsync_cycles"}, 64'(n_vs), 64'd28);
    check({tag, "_line_starts"}, 64'(n_ls), 64'd8);
    check({tag, "_frame_starts"}, 64'(n_fs), 64'd1);
    check({tag, "_misplaced"}, 64'(n_bad), 64'd0);
    check({tag, "_period"}, 64'(frame_start), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 RST_N = 1'b0;
    repeat (3) @(negedge pix_clk);
    check("rst_de", 64'(de), 64'd0);
    check("rst_hsync", 64'(hsync), 64'd0);
    check("rst_vsync", 64'(vsync), 64'd1);
    check("rst_xy", 64'({x, y}), 64'd0);
    check("rst_rgb", 64'(rgb), 64'd0);

    // Reset release with en high: (0,0) on the second edge.
    solid_rgb = 24'hC0FFEE;
    en = 1'b1;
    RST_N = 1'b1;
    @(negedge pix_clk);
    check("edge1_fs", 64'(frame_start), 64'd0);
    check("edge1_de", 64'(de), 64'd0);
    @(negedge pix_clk);
    check("edge2_fs", 64'(frame_start), 64'd1);
    check("edge2_ls", 64'(line_start), 64'd1);
    check("edge2_de", 64'(de), 64'd1);
    check("edge2_rgb", 64'(rgb), 64'hC0FFEE);
    measure_frame(1'b1, 24'hC0FFEE, "first");

    // Colour bars on the next frame.
    mode = 2'd1;
    solid_rgb = 24'h123456;
    wait_fs("bars");
    for (int i = 0; i < HT; i++) begin
      check("bars_line0", 64'(rgb),
            64'(i < HA ? (PATTERN_EN ? bar_rgb[i] : 24'h123456) : 24'h0));
      @(negedge pix_clk);
    end

    // Mode change mid-frame must not tear the current frame.
    mode = 2'd0;
    solid_rgb = 24'h123456;
    wait_fs("solid");
    wait_pix(0, 2, "y2");
    mode = 2'd3;
    for (int i = 0; i < 2 * HT; i++) begin
      if (de) check("no_tear_rgb", 64'(rgb), 64'h123456);
      @(negedge pix_clk);
    end
    wait_fs("gradient");
    wait_pix(3, 1, "p31");
    check("gradient_3_1", 64'(rgb), 64'(PATTERN_EN ? 24'h030102 : 24'h123456));

    // en drop mid-line, then re-enable.
    wait_pix(5, 1, "p51");
    en = 1'b0;
    @(negedge pix_clk);
    check("idle_de", 64'(de), 64'd0);
    check("idle_hsync", 64'(hsync), 64'd0);
    check("idle_vsync", 64'(vsync), 64'd1);
    check("idle_xy", 64'({x, y}), 64'd0);
    check("idle_rgb", 64'(rgb), 64'd0);
    repeat (3) @(negedge pix_clk);
    en = 1'b1;
    @(negedge pix_clk);
    check("reen_edge1_fs", 64'(frame_start), 64'd0);
    @(negedge pix_clk);
    check("reen_edge2_fs", 64'(frame_start), 64'd1);

    // Checkerboard request: ignored without the pattern build.
    mode = 2'd2;
    solid_rgb = 24'h00AA55;
    wait_fs("checker");
    measure_frame(1'b1, PATTERN_EN ? 24'h000000 : 24'h00AA55, "checker");

    // Randomised run with en toggles, input changes and one mid-cycle reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge pix_clk);
      if (en) begin
        if ($urandom_range(0, 199) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) solid_rgb = 24'($urandom);
      if (c == 1500) begin
        #3 RST_N = 1'b0;
        #1;
        check("async_rst_de", 64'(de), 64'd0);
        check("async_rst_sync", 64'({hsync, vsync}), 64'b01);
        check("async_rst_xy", 64'({x, y}), 64'd0);
        check("async_rst_rgb", 64'(rgb), 64'd0);
        @(negedge pix_clk);
        RST_N = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
